// File: rtl/alu_16b_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_16b_bist_ctrl
// Purpose : On-chip BIST driver for ALU_16B. It sweeps LFSR operand pairs
//           through all 16 opcodes and checks the results against a golden model.
// Rev     : 1.0
// ============================================================================
module alu_16b_bist_ctrl #(
    parameter int unsigned NUM_VECTORS = 16,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned LATENCY     = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [15:0] ALU_OUT,
    input  logic        Carry_Flag,
    input  logic        Arith_flag,
    input  logic        Logic_flag,
    input  logic        CMP_flag,
    input  logic        Shift_flag,
    output logic [15:0] A,
    output logic [15:0] B,
    output logic [3:0]  ALU_FUN,
    output logic        BUSY,
    output logic        DONE,
    output logic        PASS,
    output logic [15:0] ERR_CNT,
    output logic [3:0]  FAIL_FUN,
    output logic [15:0] FAIL_A,
    output logic [15:0] FAIL_B
);

    localparam logic [15:0] C_SEED      = (SEED == 16'h0) ? 16'hACE1 : SEED;
    localparam logic [15:0] C_LAST_VEC  = 16'(NUM_VECTORS - 1);
    localparam logic [1:0]  C_WAIT_INIT = 2'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_DRIVE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, lfsr_q, lfsr_d, vec_q, vec_d;
    logic [15:0] err_q, err_d, fa_q, fa_d, fb_q, fb_d;
    logic [3:0]  fun_q, fun_d, ffun_q, ffun_d;
    logic [1:0]  wait_q, wait_d;
    logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;

    logic [16:0] w_sum, w_diff;
    logic [15:0] w_exp_out, w_lfsr1;
    logic        w_exp_c, w_exp_ar, w_exp_lo, w_exp_cm, w_exp_sh, w_mismatch;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    assign w_lfsr1 = lfsr_step(lfsr_q);

    always_comb begin
        w_sum     = {1'b0, a_q} + {1'b0, b_q};
        w_diff    = {1'b0, a_q} - {1'b0, b_q};
        w_exp_out = 16'h0;
        w_exp_c   = 1'b0;
        w_exp_ar  = 1'b0;
        w_exp_lo  = 1'b0;
        w_exp_cm  = 1'b0;
        w_exp_sh  = 1'b0;
        case (fun_q)
            4'd0:  begin w_exp_out = w_sum[15:0];  w_exp_c = w_sum[16];  w_exp_ar = 1'b1; end
            4'd1:  begin w_exp_out = w_diff[15:0]; w_exp_c = w_diff[16]; w_exp_ar = 1'b1; end
            4'd2:  begin w_exp_out = a_q * b_q; w_exp_ar = 1'b1; end
            4'd3:  begin w_exp_out = (b_q == 16'h0) ? 16'h0 : a_q / b_q; w_exp_ar = 1'b1; end
            4'd4:  begin w_exp_out = a_q & b_q;    w_exp_lo = 1'b1; end
            4'd5:  begin w_exp_out = a_q | b_q;    w_exp_lo = 1'b1; end
            4'd6:  begin w_exp_out = ~(a_q & b_q); w_exp_lo = 1'b1; end
            4'd7:  begin w_exp_out = ~(a_q | b_q); w_exp_lo = 1'b1; end
            4'd8:  begin w_exp_out = a_q ^ b_q;    w_exp_lo = 1'b1; end
            4'd9:  begin w_exp_out = ~(a_q ^ b_q); w_exp_lo = 1'b1; end
            4'd10: begin w_exp_out = (a_q == b_q) ? 16'd1 : 16'd0; w_exp_cm = 1'b1; end
            4'd11: begin w_exp_out = (a_q > b_q)  ? 16'd2 : 16'd0; w_exp_cm = 1'b1; end
            4'd12: begin w_exp_out = (a_q < b_q)  ? 16'd3 : 16'd0; w_exp_cm = 1'b1; end
            4'd13: begin w_exp_out = a_q >> 1; w_exp_sh = 1'b1; end
            4'd14: begin w_exp_out = a_q << 1; w_exp_sh = 1'b1; end
            default: ;
        endcase
    end

    // Carry is only meaningful for add/subtract, so it is ignored elsewhere.
    assign w_mismatch = (ALU_OUT != w_exp_out) || (Arith_flag != w_exp_ar) ||
                        (Logic_flag != w_exp_lo) || (CMP_flag != w_exp_cm) ||
                        (Shift_flag != w_exp_sh) ||
                        ((fun_q <= 4'd1) && (Carry_Flag != w_exp_c));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        fun_d   = fun_q;
        lfsr_d  = lfsr_q;
        vec_d   = vec_q;
        wait_d  = wait_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        err_d   = err_q;
        ffun_d  = ffun_q;
        fa_d    = fa_q;
        fb_d    = fb_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    err_d   = 16'h0;
                    ffun_d  = 4'h0;
                    fa_d    = 16'h0;
                    fb_d    = 16'h0;
                    vec_d   = 16'h0;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                a_d     = lfsr_q;
                b_d     = w_lfsr1;
                lfsr_d  = lfsr_step(w_lfsr1);
                fun_d   = 4'h0;
                state_d = S_DRIVE;
            end
            S_DRIVE: begin
                wait_d  = C_WAIT_INIT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q == 2'd0) begin
                    state_d = S_CHECK;
                end else begin
                    wait_d = wait_q - 2'd1;
                end
            end
            S_CHECK: begin
                if (w_mismatch) begin
                    if (err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (err_q == 16'h0) begin
                        ffun_d = fun_q;
                        fa_d   = a_q;
                        fb_d   = b_q;
                    end
                end
                if (fun_q != 4'hF) begin
                    fun_d   = fun_q + 4'd1;
                    state_d = S_DRIVE;
                end else if (vec_q != C_LAST_VEC) begin
                    vec_d   = vec_q + 16'd1;
                    state_d = S_LOAD;
                end else begin
                    // The report is registered on entry so DONE appears as FIN begins.
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 16'h0);
                    fun_d   = 4'hF;
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            a_q     <= 16'h0;
            b_q     <= 16'h0;
            fun_q   <= 4'hF;
            lfsr_q  <= C_SEED;
            vec_q   <= 16'h0;
            wait_q  <= 2'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 16'h0;
            ffun_q  <= 4'h0;
            fa_q    <= 16'h0;
            fb_q    <= 16'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            fun_q   <= fun_d;
            lfsr_q  <= lfsr_d;
            vec_q   <= vec_d;
            wait_q  <= wait_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
            ffun_q  <= ffun_d;
            fa_q    <= fa_d;
            fb_q    <= fb_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign ALU_FUN  = fun_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign PASS     = pass_q;
    assign ERR_CNT  = err_q;
    assign FAIL_FUN = ffun_q;
    assign FAIL_A   = fa_q;
    assign FAIL_B   = fb_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_16b_bist_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_16b_bist_ctrl
// Purpose : Scoreboard bench for alu_16b_bist_ctrl with an attached ALU model.
// Rev     : 1.0
// ============================================================================
module tb_alu_16b_bist_ctrl;

    localparam int          NV      = 4;
    localparam int          LAT     = 1;
    localparam logic [15:0] SEED    = 16'hACE1;
    localparam int          RUN_CYC = NV * (1 + 16 * (LAT + 2));

    typedef struct packed {
        logic [15:0] out;
        logic        c, ar, lo, cm, sh;
    } alu_res_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  f;
    } op_t;

    typedef struct {
        int          err;
        bit          pass;
        logic [3:0]  ffun;
        logic [15:0] fa;
        logic [15:0] fb;
        int          done_cyc;
    } rep_t;

    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [15:0] alu_out = 16'h0;
    logic        carry = 1'b0, arith = 1'b0, logc = 1'b0, cmp = 1'b0, shft = 1'b0;
    logic [15:0] a, b, err_cnt, fa, fb;
    logic [3:0]  fun, ffun;
    logic        busy, done, pass;

    int          checks = 0, errors = 0, cyc = 0;
    int          fault_kind = 0;
    logic [3:0]  fault_fun = 4'h0;
    logic [15:0] model_lfsr = SEED;
    alu_res_t    alu_r;
    op_t         op_q[$];
    rep_t        rep_q[$];

    alu_16b_bist_ctrl #(.NUM_VECTORS(NV), .SEED(SEED), .LATENCY(LAT)) dut (
        .CLK(clk), .RST(rst_n), .START(start),
        .ALU_OUT(alu_out), .Carry_Flag(carry), .Arith_flag(arith),
        .Logic_flag(logc), .CMP_flag(cmp), .Shift_flag(shft),
        .A(a), .B(b), .ALU_FUN(fun), .BUSY(busy), .DONE(done), .PASS(pass),
        .ERR_CNT(err_cnt), .FAIL_FUN(ffun), .FAIL_A(fa), .FAIL_B(fb)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic alu_res_t alu_ref(input logic [15:0] x, input logic [15:0] y,
                                         input logic [3:0] f);
        alu_res_t r;
        longint   ix, iy;
        ix = longint'(x);
        iy = longint'(y);
        r  = '0;
        case (f)
            4'd0:  begin r.out = 16'(ix + iy); r.c = (ix + iy) > 65535; r.ar = 1'b1; end
            4'd1:  begin r.out = 16'(ix - iy); r.c = ix < iy;           r.ar = 1'b1; end
            4'd2:  begin r.out = 16'(ix * iy); r.ar = 1'b1; end
            4'd3:  begin r.out = (iy == 0) ? 16'h0 : 16'(ix / iy); r.ar = 1'b1; end
            4'd4:  begin r.out = x & y;    r.lo = 1'b1; end
            4'd5:  begin r.out = x | y;    r.lo = 1'b1; end
            4'd6:  begin r.out = ~(x & y); r.lo = 1'b1; end
            4'd7:  begin r.out = ~(x | y); r.lo = 1'b1; end
            4'd8:  begin r.out = x ^ y;    r.lo = 1'b1; end
            4'd9:  begin r.out = ~(x ^ y); r.lo = 1'b1; end
            4'd10: begin r.out = (ix == iy) ? 16'd1 : 16'd0; r.cm = 1'b1; end
            4'd11: begin r.out = (ix > iy)  ? 16'd2 : 16'd0; r.cm = 1'b1; end
            4'd12: begin r.out = (ix < iy)  ? 16'd3 : 16'd0; r.cm = 1'b1; end
            4'd13: begin r.out = 16'(ix / 2); r.sh = 1'b1; end
            4'd14: begin r.out = 16'(ix * 2); r.sh = 1'b1; end
            default: ;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    // Does the injected fault produce a visible mismatch for this operand pair?
    function automatic bit fault_hits(input int kind, input logic [3:0] ff,
                                      input logic [15:0] pa, input logic [15:0] pb);
        case (kind)
            1:       return 1'b1;
            2:       return (ff >= 4'd4) && (ff <= 4'd9);
            3:       return ff <= 4'd1;
            4:       return (ff == 4'd3) && ((pa / pb) != 16'h0);
            default: return 1'b0;
        endcase
    endfunction

    // ALU_16B stand-in: one registered stage, with optional fault injection.
    always @(posedge clk) begin
        if (fault_kind == 4 && fun == fault_fun) alu_r = alu_ref(a, 16'h0, fun);
        else                                     alu_r = alu_ref(a, b, fun);
        if (fun == fault_fun) begin
            case (fault_kind)
                1: alu_r.out[0] = ~alu_r.out[0];
                2: alu_r.lo     = 1'b0;
                3: alu_r.c      = ~alu_r.c;
                default: ;
            endcase
        end
        alu_out <= alu_r.out;
        carry   <= alu_r.c;
        arith   <= alu_r.ar;
        logc    <= alu_r.lo;
        cmp     <= alu_r.cm;
        shft    <= alu_r.sh;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input int kind, input logic [3:0] ff, input int extra_at, input int reset_at);
        op_t         op;
        rep_t        rep;
        logic [15:0] pa, pb;
        int          t0, n;
        fault_kind = kind;
        fault_fun  = ff;
        rep.err = 0; rep.ffun = 4'h0; rep.fa = 16'h0; rep.fb = 16'h0;
        for (int v = 0; v < NV; v++) begin
            pa = model_lfsr; model_lfsr = lfsr_next(model_lfsr);
            pb = model_lfsr; model_lfsr = lfsr_next(model_lfsr);
            for (int f = 0; f < 16; f++) begin
                op.a = pa; op.b = pb; op.f = 4'(f);
                op_q.push_back(op);
            end
            if (fault_hits(kind, ff, pa, pb)) begin
                if (rep.err == 0) begin
                    rep.ffun = ff; rep.fa = pa; rep.fb = pb;
                end
                rep.err++;
            end
        end
        rep.pass = (rep.err == 0);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 t0 = cyc;
        rep.done_cyc = t0 + RUN_CYC;
        if (reset_at == 0) rep_q.push_back(rep);
        @(negedge clk); start = 1'b0;
        chk("start_clear", {done, busy, err_cnt}, {1'b0, 1'b1, 16'h0});
        n = 0;
        while (!done && n < RUN_CYC + 20) begin
            @(negedge clk);
            n = cyc - t0;
            start = (n == extra_at);
            if (reset_at != 0 && n == reset_at) begin
                chk("err_before_reset", err_cnt, 64'((reset_at - 4) / (16 * (LAT + 2) + 1) + 1));
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk("mid_reset", {busy, done, pass, err_cnt, fun, a, b},
                    {1'b0, 1'b0, 1'b0, 16'h0, 4'hF, 16'h0, 16'h0});
                op_q.delete();
                model_lfsr = SEED;
                start = 1'b0;
                return;
            end
        end
        chk("done_within_bound", done, 1);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops an expected operand triple on every new drive, and a report on DONE.
    initial begin : monitor
        op_t        prev, cur, exp_op;
        rep_t       exp_rep;
        logic       done_prev;
        prev      = '0;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            cur = {a, b, fun};
            if (busy && cur != prev) begin
                if (op_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL op_unexpected: got %0h expected none", cur);
                end else begin
                    exp_op = op_q.pop_front();
                    chk("op_drive", cur, exp_op);
                end
            end
            prev = cur;
            if (done && !done_prev) begin
                if (rep_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL done_unexpected: got DONE expected none");
                end else begin
                    exp_rep = rep_q.pop_front();
                    chk("err_cnt",   err_cnt, 64'(exp_rep.err));
                    chk("pass",      pass,    exp_rep.pass);
                    chk("fail_fun",  ffun,    exp_rep.ffun);
                    chk("fail_a",    fa,      exp_rep.fa);
                    chk("fail_b",    fb,      exp_rep.fb);
                    chk("done_cycle", cyc,    exp_rep.done_cyc);
                end
            end
            done_prev = done;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int k, x, idle;
        logic [3:0] f;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ab",    {a, b}, 32'h0);
        chk("reset_fun",   fun, 4'hF);
        chk("reset_flags", {busy, done, pass}, 3'b000);
        chk("reset_err",   err_cnt, 16'h0);
        chk("reset_fail",  {ffun, fa, fb}, 36'h0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);

        run(2, 4'd4, 0, 0);
        chk("first_fail_a_seed", fa, 16'hACE1);
        chk("first_fail_b_seed", fb, 16'h59C3);
        run(0, 4'd0, 20, 0);
        run(3, 4'd5, 0, 0);
        run(3, 4'd1, 0, 0);
        run(4, 4'd3, 0, 0);
        run(1, 4'd0, 0, 50);
        repeat (3) @(negedge clk);
        run(0, 4'd0, 0, 0);
        chk("clean_pass", {pass, err_cnt}, {1'b1, 16'h0});
        for (int i = 0; i < 4; i++) begin
            k    = $urandom_range(0, 3);
            f    = 4'($urandom_range(0, 15));
            x    = ($urandom_range(0, 1) == 1) ? $urandom_range(5, 150) : 0;
            idle = $urandom_range(0, 5);
            repeat (idle) @(negedge clk);
            run(k, f, x, 0);
        end
        repeat (3) @(negedge clk);
        chk("ops_drained",     op_q.size(), 0);
        chk("reports_drained", rep_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
